// File: rtl/pipe_adder16_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder16_pkg
// Shared definitions for the nibble-serial adder: FSM state encoding,
// the slice width handled per cycle, and the legal range of NIBBLES.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_adder16_pkg;

  localparam int SLICE_W     = 4;
  localparam int NIBBLES_MIN = 2;
  localparam int NIBBLES_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_adder16_adder4.sv
// -----------------------------------------------------------------------------
// adder4
// 4-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
// -----------------------------------------------------------------------------
module adder4
  import pipe_adder16_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[SLICE_W];

endmodule

// File: rtl/pipe_adder16.sv
// -----------------------------------------------------------------------------
// pipe_adder16
// Nibble-serial unsigned adder: one 4-bit slice per cycle, LS nibble first,
// carry held in a register between slices. Result appears NIBBLES cycles
// after the operands are accepted and is held until the consumer takes it.
// Optional macro PIPE_ADDER16_OVF_EN adds a registered signed-overflow flag.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, c_in)
//   out_valid/out_ready : result handshake (sum, c_out[, ovf])
//   a, b                : W-bit unsigned operands, W = 4*NIBBLES
//   c_in                : carry into bit 0
//   sum, c_out          : registered W-bit result and carry out
//   ovf                 : (PIPE_ADDER16_OVF_EN only) two's-complement overflow
// -----------------------------------------------------------------------------
module pipe_adder16
  import pipe_adder16_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       c_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       c_out
`ifdef PIPE_ADDER16_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int DATA_W = SLICE_W * NIBBLES;
  localparam int IDX_W  = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  if (NIBBLES < NIBBLES_MIN || NIBBLES > NIBBLES_MAX) begin : g_bad_nibbles
    $error("pipe_adder16: NIBBLES out of range");
  end

  state_t             state;
  state_t             state_nxt;
  logic               rdy_en;
  logic [IDX_W-1:0]   idx;
  logic               carry_p0;
  logic [DATA_W-1:0]  a_p0;
  logic [DATA_W-1:0]  b_p0;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
  logic               accept;
  logic               last_slice;

  assign accept     = in_valid && in_ready;
  assign last_slice = (state == ADD) && (idx == IDX_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = ADD;
      ADD:  if (idx == IDX_LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; rdy_en keeps in_ready low until the first edge after reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: in_ready = rdy_en;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Stage p0: operand capture (pure data, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= a;
      b_p0 <= b;
    end
  end

  assign sl_a = a_p0[idx*SLICE_W +: SLICE_W];
  assign sl_b = b_p0[idx*SLICE_W +: SLICE_W];

  adder4 u_adder4 (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_p0),
    .s  (sl_s),
    .co (sl_co)
  );

  // Stage p1: slice accumulation; sum/c_out only change while slices are written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      idx      <= '0;
      carry_p0 <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
`ifdef PIPE_ADDER16_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        carry_p0 <= c_in;
        idx      <= '0;
      end else if (state == ADD) begin
        sum[idx*SLICE_W +: SLICE_W] <= sl_s;
        carry_p0 <= sl_co;
        if (last_slice) begin
          idx   <= '0;
          c_out <= sl_co;
`ifdef PIPE_ADDER16_OVF_EN
          // Same-sign operands producing a result of the other sign
          ovf   <= (a_p0[DATA_W-1] == b_p0[DATA_W-1]) &&
                   (sl_s[SLICE_W-1] != a_p0[DATA_W-1]);
`endif
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
